// File: rtl/mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe
// Registered MEM->WB pipeline boundary. Captures the MEM stage's write-back
// word, destination register, write enable and halt flag, and presents them
// to the register-file write port through a two-entry skid buffer.
// Also owns the retired-instruction counter and the sticky halted flag used
// by the display/debug logic.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         synchronous active-low reset
//   in_valid    MEM stage presents an instruction
//   in_ready    block accepts an instruction this cycle (registered)
//   in_data     write-back word (RegFile_Din)
//   in_rd       destination register number
//   in_we       register write enable
//   in_halt     instruction is syscall-halt
//   flush       discard all buffered entries
//   out_valid   WB entry valid (registered)
//   out_ready   register file consumes the entry this cycle
//   out_data    write-back word (registered)
//   out_rd      destination register (registered)
//   out_we      write enable, never set for register 0 (registered)
//   out_halt    halt flag of the current entry (registered)
//   retire_cnt  saturating count of entries popped since reset
//   halted      sticky; a halt instruction has retired
// -----------------------------------------------------------------------------
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_we,
    input  logic              in_halt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_we,
    output logic              out_halt,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_case_s;
    state_t              state_next_s;

    logic [DATA_W-1:0]   main_data_r,  main_data_s;
    logic [REG_W-1:0]    main_rd_r,    main_rd_s;
    logic                main_we_r,    main_we_s;
    logic                main_halt_r,  main_halt_s;

    logic [DATA_W-1:0]   skid_data_r,  skid_data_s;
    logic [REG_W-1:0]    skid_rd_r,    skid_rd_s;
    logic                skid_we_r,    skid_we_s;
    logic                skid_halt_r,  skid_halt_s;

    logic                in_ready_r,   in_ready_next_s;
    logic                out_valid_r,  out_valid_next_s;
    logic [CNT_W-1:0]    retire_cnt_r, retire_cnt_next_s;
    logic                halted_r,     halted_next_s;

    logic                accept_s;
    logic                pop_s;
    logic                halt_pop_s;
    logic                in_we_eff_s;

    // Handshake decode and next-state / next-datapath computation.
    always_comb begin
        accept_s     = in_valid & in_ready_r;
        pop_s        = out_valid_r & out_ready;
        halt_pop_s   = pop_s & main_halt_r;
        // The zero-register rule is folded in at capture so out_we is a plain flop.
        in_we_eff_s  = in_we & (in_rd != {REG_W{1'b0}});

        state_case_s = state_r;
        main_data_s  = main_data_r;
        main_rd_s    = main_rd_r;
        main_we_s    = main_we_r;
        main_halt_s  = main_halt_r;
        skid_data_s  = skid_data_r;
        skid_rd_s    = skid_rd_r;
        skid_we_s    = skid_we_r;
        skid_halt_s  = skid_halt_r;

        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_case_s = ST_ONE;
                    main_data_s  = in_data;
                    main_rd_s    = in_rd;
                    main_we_s    = in_we_eff_s;
                    main_halt_s  = in_halt;
                end else begin
                    state_case_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && pop_s) begin
                    state_case_s = ST_ONE;
                    main_data_s  = in_data;
                    main_rd_s    = in_rd;
                    main_we_s    = in_we_eff_s;
                    main_halt_s  = in_halt;
                end else if (accept_s) begin
                    state_case_s = ST_TWO;
                    skid_data_s  = in_data;
                    skid_rd_s    = in_rd;
                    skid_we_s    = in_we_eff_s;
                    skid_halt_s  = in_halt;
                end else if (pop_s) begin
                    state_case_s = ST_EMPTY;
                end else begin
                    state_case_s = ST_ONE;
                end
            end
            ST_TWO: begin
                // in_ready is low in TWO, so only a pop can move us.
                if (pop_s) begin
                    state_case_s = ST_ONE;
                    main_data_s  = skid_data_r;
                    main_rd_s    = skid_rd_r;
                    main_we_s    = skid_we_r;
                    main_halt_s  = skid_halt_r;
                end else begin
                    state_case_s = ST_TWO;
                end
            end
            default: begin
                state_case_s = ST_EMPTY;
            end
        endcase

        // Flush and a retiring halt both empty the buffer after the pop completes;
        // any accept in the same cycle is dropped.
        if (flush || halt_pop_s) begin
            state_next_s = ST_EMPTY;
        end else begin
            state_next_s = state_case_s;
        end

        // Clear stored fields whenever the buffer empties so stale entries never linger.
        if (state_next_s == ST_EMPTY) begin
            main_data_s = {DATA_W{1'b0}};
            main_rd_s   = {REG_W{1'b0}};
            main_we_s   = 1'b0;
            main_halt_s = 1'b0;
            skid_data_s = {DATA_W{1'b0}};
            skid_rd_s   = {REG_W{1'b0}};
            skid_we_s   = 1'b0;
            skid_halt_s = 1'b0;
        end else begin
            main_data_s = main_data_s;
        end

        if (pop_s && (retire_cnt_r != {CNT_W{1'b1}})) begin
            retire_cnt_next_s = retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retire_cnt_next_s = retire_cnt_r;
        end

        halted_next_s    = halted_r | halt_pop_s;
        in_ready_next_s  = (state_next_s != ST_TWO) & ~halted_next_s;
        out_valid_next_s = (state_next_s != ST_EMPTY);
    end

    // State, storage and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_EMPTY;
            main_data_r  <= {DATA_W{1'b0}};
            main_rd_r    <= {REG_W{1'b0}};
            main_we_r    <= 1'b0;
            main_halt_r  <= 1'b0;
            skid_data_r  <= {DATA_W{1'b0}};
            skid_rd_r    <= {REG_W{1'b0}};
            skid_we_r    <= 1'b0;
            skid_halt_r  <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            retire_cnt_r <= {CNT_W{1'b0}};
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            main_data_r  <= main_data_s;
            main_rd_r    <= main_rd_s;
            main_we_r    <= main_we_s;
            main_halt_r  <= main_halt_s;
            skid_data_r  <= skid_data_s;
            skid_rd_r    <= skid_rd_s;
            skid_we_r    <= skid_we_s;
            skid_halt_r  <= skid_halt_s;
            in_ready_r   <= in_ready_next_s;
            out_valid_r  <= out_valid_next_s;
            retire_cnt_r <= retire_cnt_next_s;
            halted_r     <= halted_next_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_data   = main_data_r;
    assign out_rd     = main_rd_r;
    assign out_we     = main_we_r;
    assign out_halt   = main_halt_r;
    assign retire_cnt = retire_cnt_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_pipe
// Self-checking bench for mem_wb_pipe: a hand-computed vector table covering
// streaming, backpressure, zero register, flush collision, halt and reset,
// followed by randomized traffic checked against a queue-based reference.
// A narrow counter is used so saturation is reached during the random phase.
// -----------------------------------------------------------------------------
module tb_mem_wb_pipe;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;
    localparam int NVEC   = 28;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [REG_W-1:0]  in_rd;
    logic              in_we;
    logic              in_halt;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [REG_W-1:0]  out_rd;
    logic              out_we;
    logic              out_halt;
    logic [CNT_W-1:0]  retire_cnt;
    logic              halted;

    mem_wb_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_rd(in_rd), .in_we(in_we), .in_halt(in_halt),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_we(out_we), .out_halt(out_halt),
        .retire_cnt(retire_cnt), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, iv;
        logic [31:0] d;
        logic [4:0]  rd;
        logic        we, hl, fl, ordy;
        logic        ev, er;
        logic [31:0] ed;
        logic        ewe, eha;
        logic [3:0]  ec;
        logic        eh;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        we, hl;
    } ent_t;

    vec_t tbl [NVEC];
    ent_t q[$];
    logic m_ready;
    int   m_cnt;
    logic m_halted;
    int   checks;
    int   errors;

    function automatic vec_t mkv(logic r, logic iv, logic [31:0] d, logic [4:0] rd,
                                 logic we, logic hl, logic fl, logic ordy,
                                 logic ev, logic er, logic [31:0] ed, logic ewe,
                                 logic eha, logic [3:0] ec, logic eh);
        vec_t v;
        v.rst = r;  v.iv = iv; v.d = d;   v.rd = rd;  v.we = we; v.hl = hl;
        v.fl = fl;  v.ordy = ordy;
        v.ev = ev;  v.er = er; v.ed = ed; v.ewe = ewe; v.eha = eha;
        v.ec = ec;  v.eh = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour: a FIFO of at most two entries with the handshake rules.
    task automatic model_edge();
        logic acc, pop, hpop;
        ent_t e, n;
        if (!rst) begin
            q.delete();
            m_ready  = 1'b1;
            m_cnt    = 0;
            m_halted = 1'b0;
        end else begin
            acc  = in_valid && m_ready;
            pop  = (q.size() > 0) && out_ready;
            hpop = 1'b0;
            if (pop) begin
                e = q.pop_front();
                if (m_cnt < 15) m_cnt++;
                if (e.hl) begin
                    m_halted = 1'b1;
                    hpop     = 1'b1;
                end
            end
            if (flush || hpop) begin
                q.delete();
            end else if (acc) begin
                n.d = in_data; n.rd = in_rd; n.we = in_we; n.hl = in_halt;
                q.push_back(n);
            end
            m_ready = (q.size() < 2) && !m_halted;
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [31:0] d,
                         input logic [4:0] rd, input logic we, input logic hl,
                         input logic fl, input logic ordy);
        rst = r; in_valid = iv; in_data = d; in_rd = rd; in_we = we;
        in_halt = hl; flush = fl; out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input int cyc);
        chk($sformatf("rnd%0d valid", cyc), out_valid, (q.size() != 0));
        chk($sformatf("rnd%0d in_ready", cyc), in_ready, m_ready);
        chk($sformatf("rnd%0d retire_cnt", cyc), retire_cnt, m_cnt);
        chk($sformatf("rnd%0d halted", cyc), halted, m_halted);
        if (q.size() != 0) begin
            chk($sformatf("rnd%0d data", cyc), out_data, q[0].d);
            chk($sformatf("rnd%0d rd", cyc), out_rd, q[0].rd);
            chk($sformatf("rnd%0d we", cyc), out_we, q[0].we && (q[0].rd != 5'd0));
            chk($sformatf("rnd%0d halt", cyc), out_halt, q[0].hl);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        //              rst  iv   data       rd     we   hl   fl   ordy | ev   er   ed         ewe  eha  cnt    halted
        // reset then stream
        tbl[0]  = mkv(1'b0,1'b0,32'h0,     5'd0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,32'h0,     1'b0,1'b0,4'd0,1'b0);
        tbl[1]  = mkv(1'b0,1'b0,32'h0,     5'd0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,32'h0,     1'b0,1'b0,4'd0,1'b0);
        tbl[2]  = mkv(1'b1,1'b1,32'h11,    5'd1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,32'h11,    1'b1,1'b0,4'd0,1'b0);
        tbl[3]  = mkv(1'b1,1'b1,32'h22,    5'd2,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,32'h22,    1'b1,1'b0,4'd1,1'b0);
        tbl[4]  = mkv(1'b1,1'b1,32'h33,    5'd3,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,32'h33,    1'b1,1'b0,4'd2,1'b0);
        tbl[5]  = mkv(1'b1,1'b0,32'h0,     5'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,32'h0,     1'b0,1'b0,4'd3,1'b0);
        // backpressure
        tbl[6]  = mkv(1'b1,1'b1,32'hA,     5'd4,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,32'hA,     1'b1,1'b0,4'd3,1'b0);
        tbl[7]  = mkv(1'b1,1'b1,32'hB,     5'd5,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,32'hA,     1'b1,1'b0,4'd3,1'b0);
        tbl[8]  = mkv(1'b1,1'b1,32'hC,     5'd6,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,32'hA,     1'b1,1'b0,4'd3,1'b0);
        tbl[9]  = mkv(1'b1,1'b0,32'h0,     5'd0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,32'hB,     1'b1,1'b0,4'd4,1'b0);
        tbl[10] = mkv(1'b1,1'b0,32'h0,     5'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,32'h0,     1'b0,1'b0,4'd5,1'b0);
        // zero register
        tbl[11] = mkv(1'b1,1'b1,32'hDEAD,  5'd0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,32'hDEAD,  1'b0,1'b0,4'd5,1'b0);
        tbl[12] = mkv(1'b1,1'b0,32'h0,     5'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,32'h0,     1'b0,1'b0,4'd6,1'b0);
        // flush collision in TWO
        tbl[13] = mkv(1'b1,1'b1,32'h1,     5'd1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,32'h1,     1'b1,1'b0,4'd6,1'b0);
        tbl[14] = mkv(1'b1,1'b1,32'h2,     5'd2,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,32'h1,     1'b1,1'b0,4'd6,1'b0);
        tbl[15] = mkv(1'b1,1'b1,32'h3,     5'd3,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,32'h0,     1'b0,1'b0,4'd7,1'b0);
        tbl[16] = mkv(1'b1,1'b0,32'h0,     5'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,32'h0,     1'b0,1'b0,4'd7,1'b0);
        // halt with 0x55 behind it
        tbl[17] = mkv(1'b1,1'b1,32'h0,     5'd0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,32'h0,     1'b0,1'b1,4'd7,1'b0);
        tbl[18] = mkv(1'b1,1'b1,32'h55,    5'd6,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,32'h0,     1'b0,1'b1,4'd7,1'b0);
        tbl[19] = mkv(1'b1,1'b0,32'h0,     5'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,32'h0,     1'b0,1'b0,4'd8,1'b1);
        tbl[20] = mkv(1'b1,1'b1,32'h77,    5'd7,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,32'h0,     1'b0,1'b0,4'd8,1'b1);
        tbl[21] = mkv(1'b1,1'b1,32'h78,    5'd7,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h0,     1'b0,1'b0,4'd8,1'b1);
        // reset while halted (with flush), then reset while in TWO
        tbl[22] = mkv(1'b0,1'b1,32'h79,    5'd7,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,32'h0,     1'b0,1'b0,4'd0,1'b0);
        tbl[23] = mkv(1'b1,1'b1,32'h91,    5'd1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,32'h91,    1'b1,1'b0,4'd0,1'b0);
        tbl[24] = mkv(1'b1,1'b1,32'h92,    5'd2,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,32'h91,    1'b1,1'b0,4'd0,1'b0);
        tbl[25] = mkv(1'b0,1'b1,32'h93,    5'd3,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,32'h0,     1'b0,1'b0,4'd0,1'b0);
        tbl[26] = mkv(1'b1,1'b1,32'h11,    5'd1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,32'h11,    1'b1,1'b0,4'd0,1'b0);
        tbl[27] = mkv(1'b1,1'b0,32'h0,     5'd0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,32'h0,     1'b0,1'b0,4'd1,1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].rd, tbl[i].we,
                  tbl[i].hl, tbl[i].fl, tbl[i].ordy);
            step();
            chk($sformatf("vec%0d valid", i), out_valid, tbl[i].ev);
            chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].er);
            chk($sformatf("vec%0d retire_cnt", i), retire_cnt, tbl[i].ec);
            chk($sformatf("vec%0d halted", i), halted, tbl[i].eh);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d data", i), out_data, tbl[i].ed);
                chk($sformatf("vec%0d we", i), out_we, tbl[i].ewe);
                chk($sformatf("vec%0d halt", i), out_halt, tbl[i].eha);
            end
        end

        // Randomized traffic against the queue model.
        drive(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_model(-1);
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 64) != 0,
                  ($urandom % 4) != 0,
                  $urandom,
                  5'($urandom % 32),
                  ($urandom % 4) != 0,
                  ($urandom % 24) == 0,
                  ($urandom % 16) == 0,
                  ($urandom % 3) != 0);
            step();
            check_model(c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
